audio_frame_controller: RTL and testbench
=========================================

AUDIO_FRAME_CONTROLLER -- requirements
Module: audio_frame_controller

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning sample width in bits.
REQ-002 SHALL have parameter FRAME_SIZE, default 256, meaning samples per half buffer (power of two).
REQ-003 SHALL derive localparam ADDRESS_WIDTH = $clog2(2*FRAME_SIZE) and INDEX_WIDTH = $clog2(FRAME_SIZE).
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 eoc  input  1  ADC end-of-conversion, asynchronous to clk.
REQ-007 din  input  DATA_WIDTH  ADC sample, stable while eoc high.
REQ-008 ram_address  output  ADDRESS_WIDTH  shared single-port buffer address.
REQ-009 ram_data_in  output  DATA_WIDTH  buffer write data.
REQ-010 ram_write  output  1  buffer write strobe.
REQ-011 ram_data_out  input  DATA_WIDTH  buffer read data, valid one cycle after address.
REQ-012 win_data / win_index / win_valid  output  DATA_WIDTH / INDEX_WIDTH / 1  frame stream to pitch engine.
REQ-013 engine_start  output  1  one-cycle pulse: frame loaded, begin search.
REQ-014 engine_ready / engine_result  input  1 / 8  engine done; result tau (0 = no pitch).
REQ-015 tau / tau_valid / overrun  output  8 / 1 / 1  latest pitch, one-cycle update pulse, sticky frame-drop flag.

Function
REQ-016 SHALL synchronise eoc through two flops and detect rising edge on the synchronised signal.
REQ-017 On each detected edge SHALL register din and issue one write, the next cycle, to fill_half*FRAME_SIZE + fill_index.
REQ-018 fill_index SHALL increment per write; at FRAME_SIZE-1 it wraps to 0, fill_half toggles, and the completed half is posted as pending.
REQ-019 If a half completes while a frame is already pending, pending half SHALL be replaced by the newest and overrun SHALL set until reset.
REQ-020 RAM port arbitration: capture write SHALL have priority; a copy read scheduled in a write cycle SHALL be deferred one cycle, no read lost or duplicated.
REQ-021 Control FSM states: IDLE, COPY, DRAIN, WAIT_ENGINE.
REQ-022 IDLE -> COPY when pending set; SHALL latch copy_half, clear pending the same cycle, copy_index = 0.
REQ-023 COPY SHALL issue reads copy_half*FRAME_SIZE + copy_index, incrementing per issued read; after index FRAME_SIZE-1 issued -> DRAIN.
REQ-024 Each read SHALL produce win_valid exactly two cycles after issue, win_data = ram_data_out registered, win_index = issued index.
REQ-025 DRAIN SHALL wait until the last win_valid, then pulse engine_start the following cycle and enter WAIT_ENGINE.
REQ-026 WAIT_ENGINE on engine_ready: result != 0 -> tau <= result, tau_valid pulses one cycle; result == 0 -> tau held, no pulse; -> IDLE.
REQ-027 Capture SHALL continue uninterrupted in all FSM states; copy never reads the half being filled.
REQ-028 ram_write deasserted SHALL leave ram_address driven by pending read or 0; ram_data_in don't-care when ram_write low.

Reset
REQ-029 Reset SHALL force: state IDLE, fill_half 0, fill_index 0, copy_index 0, pending 0, sync flops 0, ram_write 0, ram_address 0, win_valid 0, engine_start 0, tau 0, tau_valid 0, overrun 0.
REQ-030 Reset mid-COPY or mid-WAIT_ENGINE SHALL abort without issuing engine_start; engine_ready ignored until next WAIT_ENGINE.
REQ-031 Reset asserted with eoc high SHALL not produce a write on release until a fresh rising edge.

Verification
REQ-032 FRAME_SIZE=4, 4 eoc edges with din 10,11,12,13 -> writes addr 0..3, then win_index 0..3 / win_data 10..13, one engine_start.
REQ-033 eoc edge during COPY -> write at fill address that cycle, read deferred one cycle, win stream still complete and ordered.
REQ-034 engine_result 42 -> tau=42, tau_valid 1 cycle; next result 0 -> tau stays 42, no pulse.
REQ-035 engine held not ready while 2 further halves complete -> overrun=1, next copy uses newest half (addr base 0 vs 4 as expected).
REQ-036 Reset pulse mid-COPY -> all outputs at REQ-029 values next cycle, no engine_start, fill restarts at addr 0.

Source files
------------

// File: rtl/audio_frame_controller.sv
// Double-buffered ADC capture into a shared single-port RAM, with frame copy-out
// to a pitch engine and a latched pitch result.
module audio_frame_controller #(
    parameter int DATA_WIDTH = 8,
    parameter int FRAME_SIZE = 256,
    localparam int ADDRESS_WIDTH = $clog2(2*FRAME_SIZE),
    localparam int INDEX_WIDTH = $clog2(FRAME_SIZE)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     eoc,
    input  logic [DATA_WIDTH-1:0]    din,
    output logic [ADDRESS_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0]    ram_data_in,
    output logic                     ram_write,
    input  logic [DATA_WIDTH-1:0]    ram_data_out,
    output logic [DATA_WIDTH-1:0]    win_data,
    output logic [INDEX_WIDTH-1:0]   win_index,
    output logic                     win_valid,
    output logic                     engine_start,
    input  logic                     engine_ready,
    input  logic [7:0]               engine_result,
    output logic [7:0]               tau,
    output logic                     tau_valid,
    output logic                     overrun
);
    localparam logic [INDEX_WIDTH-1:0] LAST = INDEX_WIDTH'(FRAME_SIZE - 1);

    typedef enum logic [1:0] {IDLE, COPY, DRAIN, WAIT_ENGINE} state_t;
    state_t state, state_next;

    logic                   eoc_s1, eoc_s2, eoc_prev, armed, eoc_rise;
    logic [1:0]             settle;
    logic [DATA_WIDTH-1:0]  sample_q;
    logic                   wr_pend;
    logic                   fill_half, pend_half, pending;
    logic [INDEX_WIDTH-1:0] fill_index;
    logic                   copy_half;
    logic [INDEX_WIDTH-1:0] copy_index, rd_idx1;
    logic                   rd_v1;
    logic                   take, rd_issue, last_issue, start_d, accept;

    // An edge only counts once the synchroniser holds real samples and has seen
    // eoc low, so eoc held high across reset cannot fake a rising edge.
    assign eoc_rise = eoc_s2 & ~eoc_prev & armed;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:        if (pending)      state_next = COPY;
            COPY:        if (last_issue)   state_next = DRAIN;
            DRAIN:       if (start_d)      state_next = WAIT_ENGINE;
            WAIT_ENGINE: if (engine_ready) state_next = IDLE;
            default:                       state_next = IDLE;
        endcase
    end

    always_comb begin
        take       = (state == IDLE) && pending;
        rd_issue   = (state == COPY) && !wr_pend;
        last_issue = rd_issue && (copy_index == LAST);
        start_d    = (state == DRAIN) && win_valid && (win_index == LAST);
        accept     = (state == WAIT_ENGINE) && engine_ready;
    end

    // Capture writes own the port; a copy read in the same cycle simply waits.
    always_comb begin
        ram_write   = wr_pend;
        ram_data_in = sample_q;
        if (wr_pend)       ram_address = {fill_half, fill_index};
        else if (rd_issue) ram_address = {copy_half, copy_index};
        else               ram_address = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            eoc_s1       <= 1'b0;
            eoc_s2       <= 1'b0;
            eoc_prev     <= 1'b0;
            settle       <= '0;
            armed        <= 1'b0;
            sample_q     <= '0;
            wr_pend      <= 1'b0;
            fill_half    <= 1'b0;
            fill_index   <= '0;
            pending      <= 1'b0;
            pend_half    <= 1'b0;
            overrun      <= 1'b0;
            copy_half    <= 1'b0;
            copy_index   <= '0;
            rd_v1        <= 1'b0;
            rd_idx1      <= '0;
            win_valid    <= 1'b0;
            win_data     <= '0;
            win_index    <= '0;
            engine_start <= 1'b0;
            tau          <= '0;
            tau_valid    <= 1'b0;
        end else begin
            eoc_s1   <= eoc;
            eoc_s2   <= eoc_s1;
            eoc_prev <= eoc_s2;
            settle   <= {settle[0], 1'b1};
            armed    <= armed | (settle[1] & ~eoc_s2);

            wr_pend <= eoc_rise;
            if (eoc_rise) sample_q <= din;

            // A completion in the same cycle IDLE takes the old frame re-posts pending.
            if (take) pending <= 1'b0;
            if (wr_pend) begin
                fill_index <= fill_index + 1'b1;
                if (fill_index == LAST) begin
                    fill_half <= ~fill_half;
                    pend_half <= fill_half;
                    pending   <= 1'b1;
                    if (pending && !take) overrun <= 1'b1;
                end
            end

            if (take) begin
                copy_half  <= pend_half;
                copy_index <= '0;
            end else if (rd_issue) begin
                copy_index <= copy_index + 1'b1;
            end

            rd_v1     <= rd_issue;
            rd_idx1   <= copy_index;
            win_valid <= rd_v1;
            if (rd_v1) begin
                win_data  <= ram_data_out;
                win_index <= rd_idx1;
            end

            engine_start <= start_d;
            tau_valid    <= 1'b0;
            if (accept && engine_result != 8'd0) begin
                tau       <= engine_result;
                tau_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_audio_frame_controller.sv
// Directed bench for audio_frame_controller: sample-order model plus frame
// scoreboard, checked every cycle, with literal expectations on key points.
module tb_audio_frame_controller;
    localparam int DW = 8;
    localparam int FS = 4;
    localparam int AW = 3;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          reset, eoc, ram_write, win_valid, engine_start, engine_ready;
    logic          tau_valid, overrun;
    logic [DW-1:0] din, ram_data_in, win_data;
    logic [DW-1:0] ram_data_out = '0;
    logic [AW-1:0] ram_address;
    logic [IW-1:0] win_index;
    logic [7:0]    engine_result, tau;

    always #5 clk = ~clk;

    audio_frame_controller #(.DATA_WIDTH(DW), .FRAME_SIZE(FS)) dut (
        .clk(clk), .reset(reset), .eoc(eoc), .din(din),
        .ram_address(ram_address), .ram_data_in(ram_data_in), .ram_write(ram_write),
        .ram_data_out(ram_data_out), .win_data(win_data), .win_index(win_index),
        .win_valid(win_valid), .engine_start(engine_start), .engine_ready(engine_ready),
        .engine_result(engine_result), .tau(tau), .tau_valid(tau_valid), .overrun(overrun)
    );

    logic [DW-1:0] mem [2*FS];
    always @(posedge clk) begin
        if (ram_write) mem[ram_address] <= ram_data_in;
        ram_data_out <= mem[ram_address];
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: samples land at (sample number mod 2*FS); a completed half becomes
    // the single pending frame, replaced (and overrun flagged) if one is waiting.
    typedef struct { int addr; int data; } wr_t;
    wr_t wq[$];
    int  n_samples = 0;
    int  frame_mem [2*FS];
    int  slot [FS];
    int  cur [FS];
    bit  slot_full = 0;
    bit  ovr_exp = 0;
    int  exp_idx = 0;
    bit  start_due = 0;
    int  exp_tau = 0;
    int  pulses_exp = 0;
    int  pulses_seen = 0;
    int  starts_seen = 0;

    task automatic model_push(input int d);
        int a;
        a = n_samples % (2*FS);
        wq.push_back('{a, d});
        frame_mem[a] = d;
        n_samples++;
        if (a % FS == FS-1) begin
            if (slot_full) ovr_exp = 1;
            for (int i = 0; i < FS; i++) slot[i] = frame_mem[a-(FS-1)+i];
            slot_full = 1;
        end
    endtask

    task automatic model_clear();
        wq.delete();
        n_samples = 0;
        slot_full = 0;
        ovr_exp = 0;
        exp_idx = 0;
        start_due = 0;
        exp_tau = 0;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (ram_write) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    chk("write_addr", int'(ram_address), e.addr);
                    chk("write_data", int'(ram_data_in), e.data);
                end
            end
            chk("engine_start", int'(engine_start), int'(start_due));
            if (engine_start) starts_seen++;
            start_due = 0;
            if (win_valid) begin
                chk("win_index", int'(win_index), exp_idx);
                if (exp_idx == 0) begin
                    chk("frame_pending", int'(slot_full), 1);
                    for (int i = 0; i < FS; i++) cur[i] = slot[i];
                    slot_full = 0;
                end
                chk("win_data", int'(win_data), cur[exp_idx]);
                exp_idx = (exp_idx + 1) % FS;
                if (exp_idx == 0) start_due = 1;
            end
            if (tau_valid) begin
                pulses_seen++;
                chk("tau_on_pulse", int'(tau), exp_tau);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic sample(input int d, input int hi, input int lo);
        din = DW'(d);
        eoc = 1'b1;
        model_push(d);
        step(hi);
        eoc = 1'b0;
        step(lo);
    endtask

    task automatic wait_start(input int target);
        int k;
        for (k = 0; k < 300; k++) begin
            if (starts_seen >= target) break;
            step(1);
        end
        chk("engine_start_reached", int'(starts_seen >= target), 1);
    endtask

    task automatic respond(input int r);
        engine_result = 8'(r);
        engine_ready = 1'b1;
        if (r != 0) begin
            exp_tau = r;
            pulses_exp++;
        end
        step(1);
        engine_ready = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ram_write"}, int'(ram_write), 0);
        chk({tag, "_ram_address"}, int'(ram_address), 0);
        chk({tag, "_win_valid"}, int'(win_valid), 0);
        chk({tag, "_engine_start"}, int'(engine_start), 0);
        chk({tag, "_tau"}, int'(tau), 0);
        chk({tag, "_tau_valid"}, int'(tau_valid), 0);
        chk({tag, "_overrun"}, int'(overrun), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2*FS; i++) mem[i] = '0;
        reset = 1'b1; eoc = 1'b0; din = '0; engine_ready = 1'b0; engine_result = '0;
        step(2);
        chk_reset_outputs("por");
        reset = 1'b0;
        step(4);

        // Frame 1: addresses 0..3, stream 10..13, one engine_start.
        for (int i = 0; i < 4; i++) sample(10 + i, 4, 4);
        wait_start(1);
        respond(42);
        chk("tau_after_42", int'(tau), 42);
        chk("tau_valid_after_42", int'(tau_valid), 1);
        step(1);
        chk("tau_valid_one_cycle", int'(tau_valid), 0);

        // Frame 2 with fast samples; sample 24 is written while the copy runs.
        for (int i = 0; i < 5; i++) sample(20 + i, 2, 2);
        wait_start(2);
        respond(0);
        chk("tau_held_on_zero", int'(tau), 42);
        chk("no_pulse_on_zero", int'(tau_valid), 0);
        chk("overrun_clear", int'(overrun), 0);

        // Frame 3 then two more halves while the engine stalls.
        for (int i = 0; i < 3; i++) sample(25 + i, 4, 4);
        wait_start(3);
        for (int i = 0; i < 8; i++) sample(30 + i, 4, 4);
        chk("overrun_set", int'(overrun), 1);
        chk("overrun_model", int'(overrun), int'(ovr_exp));
        respond(0);
        wait_start(4);
        respond(7);
        chk("tau_after_7", int'(tau), 7);
        chk("tau_valid_after_7", int'(tau_valid), 1);
        step(2);
        chk("overrun_sticky", int'(overrun), 1);

        // Frame 5: reset while the copy is in progress, eoc held high through it.
        for (int i = 0; i < 4; i++) sample(40 + i, 4, 4);
        begin
            int k;
            for (k = 0; k < 100; k++) begin
                if (win_valid) break;
                step(1);
            end
            chk("copy_began", int'(k < 100), 1);
        end
        reset = 1'b1;
        eoc = 1'b1;
        din = 8'd99;
        step(1);
        model_clear();
        chk_reset_outputs("mid_copy");
        step(1);
        reset = 1'b0;
        engine_result = 8'd99;
        engine_ready = 1'b1;
        step(1);
        engine_ready = 1'b0;
        step(8);
        chk("tau_after_stray_ready", int'(tau), 0);
        chk("no_write_eoc_held", int'(wq.size()), 0);
        eoc = 1'b0;
        step(4);
        sample(50, 4, 4);
        step(4);
        chk("writes_all_seen", int'(wq.size()), 0);
        chk("fill_restart_data", int'(mem[0]), 50);
        chk("tau_pulse_count", pulses_seen, pulses_exp);
        chk("engine_start_count", starts_seen, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
